// File: rtl/alu_issue_decode_pkg.sv
// Shared definitions for the ALU issue/decode slice.
// Holds the one-hot ALU control encodings, the MIPS opcode/funct
// constants, the operand-selection enum and the decoded-op bundle
// that travels through the skid buffer.
package alu_issue_decode_pkg;

    localparam int CTRL_W = 15;
    localparam int REG_AW = 5;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // One-hot ALU control; bit 14 is reserved and never driven.
    localparam logic [CTRL_W-1:0] ALU_NONE = 15'h0000;
    localparam logic [CTRL_W-1:0] ALU_ADD  = 15'h0001;
    localparam logic [CTRL_W-1:0] ALU_ADDU = 15'h0002;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 15'h0004;
    localparam logic [CTRL_W-1:0] ALU_SUBU = 15'h0008;
    localparam logic [CTRL_W-1:0] ALU_AND  = 15'h0010;
    localparam logic [CTRL_W-1:0] ALU_OR   = 15'h0020;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 15'h0040;
    localparam logic [CTRL_W-1:0] ALU_NOR  = 15'h0080;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 15'h0100;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 15'h0200;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 15'h0400;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 15'h0800;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 15'h1000;
    localparam logic [CTRL_W-1:0] ALU_LUI  = 15'h2000;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // How the two ALU operands are formed; SEL_NONE marks a non-ALU op.
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_REG_REG,
        SEL_SHAMT,
        SEL_SIGN_IMM,
        SEL_ZERO_IMM,
        SEL_LUI
    } operand_sel_e;

    typedef struct packed {
        logic [CTRL_W-1:0] alu_ctrl;
        logic [31:0]       alu_da;
        logic [31:0]       alu_db;
        logic [REG_AW-1:0] wr_addr;
        logic              wr_en;
        logic              ovf_chk;
        logic              illegal;
    } decoded_op_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Purely combinational MIPS ALU-class decoder.
// Ports:
//   instr   in   32  instruction word
//   rs_data in   32  GPR[rs]
//   rt_data in   32  GPR[rt]
//   dec     out  decoded_op_t  control word, operands, destination, flags
module alu_op_decoder
    import alu_issue_decode_pkg::*;
(
    input  logic [31:0]  instr,
    input  logic [31:0]  rs_data,
    input  logic [31:0]  rt_data,
    output decoded_op_t  dec
);

    logic [5:0]   op;
    logic [5:0]   fn;
    logic [4:0]   rt_idx;
    logic [4:0]   rd_idx;
    logic [4:0]   sa;
    logic [15:0]  imm;
    logic [CTRL_W-1:0] ctrl;
    operand_sel_e sel;
    logic         ovf;
    logic         unused_rs_field;

    assign op     = instr[31:26];
    assign rt_idx = instr[20:16];
    assign rd_idx = instr[15:11];
    assign sa     = instr[10:6];
    assign fn     = instr[5:0];
    assign imm    = instr[15:0];

    // The rs field is not needed here: its value arrives as rs_data.
    assign unused_rs_field = ^instr[25:21];

    // Opcode/funct to ALU operation and operand-forming rule.
    always_comb begin
        ctrl = ALU_NONE;
        sel  = SEL_NONE;
        ovf  = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_ADD:  begin ctrl = ALU_ADD;  sel = SEL_REG_REG; ovf = 1'b1; end
                    FN_ADDU: begin ctrl = ALU_ADDU; sel = SEL_REG_REG; end
                    FN_SUB:  begin ctrl = ALU_SUB;  sel = SEL_REG_REG; ovf = 1'b1; end
                    FN_SUBU: begin ctrl = ALU_SUBU; sel = SEL_REG_REG; end
                    FN_AND:  begin ctrl = ALU_AND;  sel = SEL_REG_REG; end
                    FN_OR:   begin ctrl = ALU_OR;   sel = SEL_REG_REG; end
                    FN_XOR:  begin ctrl = ALU_XOR;  sel = SEL_REG_REG; end
                    FN_NOR:  begin ctrl = ALU_NOR;  sel = SEL_REG_REG; end
                    FN_SLT:  begin ctrl = ALU_SLT;  sel = SEL_REG_REG; end
                    FN_SLTU: begin ctrl = ALU_SLTU; sel = SEL_REG_REG; end
                    FN_SLL:  begin ctrl = ALU_SLL;  sel = SEL_SHAMT;   end
                    FN_SRL:  begin ctrl = ALU_SRL;  sel = SEL_SHAMT;   end
                    FN_SRA:  begin ctrl = ALU_SRA;  sel = SEL_SHAMT;   end
                    FN_SLLV: begin ctrl = ALU_SLL;  sel = SEL_REG_REG; end
                    FN_SRLV: begin ctrl = ALU_SRL;  sel = SEL_REG_REG; end
                    FN_SRAV: begin ctrl = ALU_SRA;  sel = SEL_REG_REG; end
                    default: ;
                endcase
            end
            OP_ADDI:  begin ctrl = ALU_ADD;  sel = SEL_SIGN_IMM; ovf = 1'b1; end
            OP_ADDIU: begin ctrl = ALU_ADDU; sel = SEL_SIGN_IMM; end
            OP_SLTI:  begin ctrl = ALU_SLT;  sel = SEL_SIGN_IMM; end
            OP_SLTIU: begin ctrl = ALU_SLTU; sel = SEL_SIGN_IMM; end
            OP_ANDI:  begin ctrl = ALU_AND;  sel = SEL_ZERO_IMM; end
            OP_ORI:   begin ctrl = ALU_OR;   sel = SEL_ZERO_IMM; end
            OP_XORI:  begin ctrl = ALU_XOR;  sel = SEL_ZERO_IMM; end
            OP_LUI:   begin ctrl = ALU_LUI;  sel = SEL_LUI;      end
            default: ;
        endcase
    end

    // Operand packing and write-back target. Register-to-register ops
    // write rd, immediate ops write rt; a write to $0 is suppressed.
    always_comb begin
        dec          = '0;
        dec.alu_ctrl = ctrl;
        dec.ovf_chk  = ovf;
        dec.illegal  = (sel == SEL_NONE);
        case (sel)
            SEL_REG_REG:  begin dec.alu_da = rs_data;        dec.alu_db = rt_data; end
            SEL_SHAMT:    begin dec.alu_da = {27'b0, sa};    dec.alu_db = rt_data; end
            SEL_SIGN_IMM: begin dec.alu_da = rs_data;        dec.alu_db = {{16{imm[15]}}, imm}; end
            SEL_ZERO_IMM: begin dec.alu_da = rs_data;        dec.alu_db = {16'b0, imm}; end
            SEL_LUI:      begin dec.alu_da = ZeroWord;       dec.alu_db = {16'b0, imm}; end
            default:      begin dec.alu_da = ZeroWord;       dec.alu_db = ZeroWord; end
        endcase
        if (sel != SEL_NONE) begin
            dec.wr_addr = (op == OP_SPECIAL) ? rd_idx : rt_idx;
        end
        dec.wr_en = (sel != SEL_NONE) && (dec.wr_addr != '0);
    end

endmodule

// File: rtl/alu_issue_decode.sv
// Decode/issue stage in front of the ALU: decodes an instruction with its
// register read data and hands it to EX through a registered valid/ready
// interface backed by a 2-entry skid buffer.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   flush                  drop all held and incoming ops
//   in_valid / in_ready    upstream handshake (in_ready is a flop)
//   instr, rs_data, rt_data  instruction and GPR[rs]/GPR[rt]
//   out_valid / out_ready  downstream handshake
//   alu_ctrl, alu_da, alu_db, wr_addr, wr_en, ovf_chk, illegal  decoded op
module alu_issue_decode
    import alu_issue_decode_pkg::*;
#(
    parameter int CTRL_W = 15,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [31:0]       alu_da,
    output logic [31:0]       alu_db,
    output logic [REG_AW-1:0] wr_addr,
    output logic              wr_en,
    output logic              ovf_chk,
    output logic              illegal
);

    decoded_op_t dec;
    decoded_op_t head;
    decoded_op_t tail;
    logic [1:0]  occ;
    logic [1:0]  occ_nxt;
    logic        push;
    logic        pop;

    alu_op_decoder u_decoder (
        .instr   (instr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .dec     (dec)
    );

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (occ != 2'd0);

    // Occupancy after this cycle's transfers; accept+emit leaves it unchanged.
    always_comb begin
        occ_nxt = occ;
        if (push && !pop) begin
            occ_nxt = occ + 2'd1;
        end else if (pop && !push) begin
            occ_nxt = occ - 2'd1;
        end
    end

    // Head is what EX sees; tail only fills while the head is stalled.
    // in_ready is registered from the next occupancy, so it drops the cycle
    // after the second entry is written and the buffer can never overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= 2'd0;
            in_ready <= 1'b1;
            head     <= '0;
            tail     <= '0;
        end else if (flush) begin
            occ      <= 2'd0;
            in_ready <= 1'b1;
        end else begin
            occ      <= occ_nxt;
            in_ready <= (occ_nxt != 2'd2);
            if (push && !pop) begin
                if (occ == 2'd0) begin
                    head <= dec;
                end else begin
                    tail <= dec;
                end
            end else if (pop && !push) begin
                head <= tail;
            end else if (push && pop) begin
                if (occ == 2'd2) begin
                    head <= tail;
                    tail <= dec;
                end else begin
                    head <= dec;
                end
            end
        end
    end

    // Outputs read as zero whenever no op is being presented.
    always_comb begin
        alu_ctrl = '0;
        alu_da   = '0;
        alu_db   = '0;
        wr_addr  = '0;
        wr_en    = 1'b0;
        ovf_chk  = 1'b0;
        illegal  = 1'b0;
        if (out_valid) begin
            alu_ctrl = head.alu_ctrl;
            alu_da   = head.alu_da;
            alu_db   = head.alu_db;
            wr_addr  = head.wr_addr;
            wr_en    = head.wr_en;
            ovf_chk  = head.ovf_chk;
            illegal  = head.illegal;
        end
    end

endmodule

// File: tb/tb_alu_issue_decode.sv
// Self-checking bench for alu_issue_decode: directed scenarios followed by
// randomized traffic, all compared against a table-driven reference model
// and a queue standing in for the skid buffer.
module tb_alu_issue_decode;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] alu_ctrl;
    logic [31:0] alu_da;
    logic [31:0] alu_db;
    logic [4:0]  wr_addr;
    logic        wr_en;
    logic        ovf_chk;
    logic        illegal;

    alu_issue_decode dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .alu_da    (alu_da),
        .alu_db    (alu_db),
        .wr_addr   (wr_addr),
        .wr_en     (wr_en),
        .ovf_chk   (ovf_chk),
        .illegal   (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [14:0] ctrl;
        logic [31:0] da;
        logic [31:0] db;
        logic [4:0]  wa;
        logic        we;
        logic        ovf;
        logic        ill;
    } exp_t;

    exp_t q[$];
    logic mReady;
    int   checkCount = 0;
    int   failCount  = 0;

    // Opcode/funct tables: bit index into the one-hot word and operand kind
    // (0 reg/reg, 1 shift amount, 2 sign imm, 3 zero imm, 4 lui).
    int rIdx[64];
    int rKind[64];
    int iIdx[64];
    int iKind[64];
    int legalFn[16] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27,
                        'h2A, 'h2B, 'h00, 'h02, 'h03, 'h04, 'h06, 'h07};

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic exp_t modelDecode(input logic [31:0] ins, input logic [31:0] rs,
                                         input logic [31:0] rt);
        exp_t e;
        int   idx;
        int   kind;
        int   op = int'(ins[31:26]);
        int   fn = int'(ins[5:0]);
        logic [15:0] imm = ins[15:0];
        e = '{default: '0};
        idx  = (op == 0) ? rIdx[fn] : iIdx[op];
        kind = (op == 0) ? rKind[fn] : iKind[op];
        if (idx < 0) begin
            e.ill = 1'b1;
            return e;
        end
        e.ctrl = 15'(1) << idx;
        e.ovf  = (idx == 0) || (idx == 2);
        case (kind)
            0: begin e.da = rs;                 e.db = rt; end
            1: begin e.da = 32'(ins[10:6]);     e.db = rt; end
            2: begin e.da = rs;                 e.db = 32'($signed(imm)); end
            3: begin e.da = rs;                 e.db = 32'(imm); end
            default: begin e.da = 0;            e.db = 32'(imm); end
        endcase
        e.wa = (op == 0) ? ins[15:11] : ins[20:16];
        e.we = (e.wa != 0);
        return e;
    endfunction

    function automatic logic [31:0] rInstr(input int rs, input int rt, input int rd,
                                           input int sa, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sa), 6'(fn)};
    endfunction

    function automatic logic [31:0] iInstr(input int op, input int rs, input int rt,
                                           input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] randInstr();
        case ($urandom_range(0, 3))
            0: return rInstr($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                             $urandom_range(0, 31), legalFn[$urandom_range(0, 15)]);
            1: return iInstr($urandom_range(8, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                             $urandom_range(0, 65535));
            2: return $urandom;
            default: return rInstr($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                                   $urandom_range(0, 31), $urandom_range(0, 63));
        endcase
    endfunction

    task automatic compareOutputs();
        exp_t e;
        checkOutput("out_valid", 64'(out_valid), 64'(q.size() != 0));
        checkOutput("in_ready", 64'(in_ready), 64'(mReady));
        if (q.size() != 0) begin
            e = q[0];
            checkOutput("alu_ctrl", 64'(alu_ctrl), 64'(e.ctrl));
            checkOutput("alu_da", 64'(alu_da), 64'(e.da));
            checkOutput("alu_db", 64'(alu_db), 64'(e.db));
            checkOutput("wr_addr", 64'(wr_addr), 64'(e.wa));
            checkOutput("wr_en", 64'(wr_en), 64'(e.we));
            checkOutput("ovf_chk", 64'(ovf_chk), 64'(e.ovf));
            checkOutput("illegal", 64'(illegal), 64'(e.ill));
        end
    endtask

    // Called at a falling edge: checks what the last rising edge produced,
    // drives one cycle of inputs, advances the model and moves to the next
    // falling edge.
    task automatic applyStimulus(input logic vld, input logic [31:0] ins,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic ordy, input logic fl);
        logic push;
        logic pop;
        compareOutputs();
        in_valid  = vld;
        instr     = ins;
        rs_data   = rs;
        rt_data   = rt;
        out_ready = ordy;
        flush     = fl;
        push = vld && mReady;
        pop  = (q.size() != 0) && ordy;
        if (fl) begin
            q.delete();
            mReady = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(modelDecode(ins, rs, rt));
            mReady = (q.size() < 2);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rIdx[i] = -1; rKind[i] = 0; iIdx[i] = -1; iKind[i] = 0;
        end
        rIdx['h20] = 0;  rIdx['h21] = 1;  rIdx['h22] = 2;  rIdx['h23] = 3;
        rIdx['h24] = 4;  rIdx['h25] = 5;  rIdx['h26] = 6;  rIdx['h27] = 7;
        rIdx['h2A] = 8;  rIdx['h2B] = 9;
        rIdx['h00] = 10; rKind['h00] = 1;
        rIdx['h02] = 11; rKind['h02] = 1;
        rIdx['h03] = 12; rKind['h03] = 1;
        rIdx['h04] = 10; rIdx['h06] = 11; rIdx['h07] = 12;
        iIdx['h08] = 0;  iKind['h08] = 2;
        iIdx['h09] = 1;  iKind['h09] = 2;
        iIdx['h0A] = 8;  iKind['h0A] = 2;
        iIdx['h0B] = 9;  iKind['h0B] = 2;
        iIdx['h0C] = 4;  iKind['h0C] = 3;
        iIdx['h0D] = 5;  iKind['h0D] = 3;
        iIdx['h0E] = 6;  iKind['h0E] = 3;
        iIdx['h0F] = 13; iKind['h0F] = 4;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs_data = '0; rt_data = '0;
        mReady = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("[TB] checking reset state");
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        checkOutput("rst_da_db", {alu_da, alu_db}, 64'd0);
        checkOutput("rst_flags", 64'({wr_addr, wr_en, ovf_chk, illegal}), 64'd0);
        rst = 1'b0;

        // ADDU $3,$1,$2
        applyStimulus(1'b1, rInstr(1, 2, 3, 0, 'h21), 32'd5, 32'd7, 1'b1, 1'b0);
        checkOutput("t1_ctrl", 64'(alu_ctrl), 64'h0002);
        checkOutput("t1_da", 64'(alu_da), 64'd5);
        checkOutput("t1_db", 64'(alu_db), 64'd7);
        checkOutput("t1_wr", 64'({wr_addr, wr_en, ovf_chk}), 64'({5'd3, 1'b1, 1'b0}));

        // SRA $4,$2,3
        applyStimulus(1'b1, rInstr(0, 2, 4, 3, 'h03), 32'h1234, 32'h8000_0000, 1'b1, 1'b0);
        checkOutput("t2_ctrl", 64'(alu_ctrl), 64'h1000);
        checkOutput("t2_da", 64'(alu_da), 64'd3);
        checkOutput("t2_db", 64'(alu_db), 64'h8000_0000);
        checkOutput("t2_wr_addr", 64'(wr_addr), 64'd4);

        // ADDI / ORI with imm 0xFFFF
        applyStimulus(1'b1, iInstr('h08, 1, 5, 'hFFFF), 32'd9, 32'd0, 1'b1, 1'b0);
        checkOutput("t3_addi_db", 64'(alu_db), 64'hFFFF_FFFF);
        checkOutput("t3_addi_ovf", 64'(ovf_chk), 64'd1);
        applyStimulus(1'b1, iInstr('h0D, 1, 5, 'hFFFF), 32'd9, 32'd0, 1'b1, 1'b0);
        checkOutput("t3_ori_db", 64'(alu_db), 64'h0000_FFFF);
        checkOutput("t3_ori_ovf", 64'(ovf_chk), 64'd0);
        idle(2);

        // Back-pressure: four stalled cycles with input always offered
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, rInstr(1, 2, 10 + i, 0, 'h24), 32'(100 + i), 32'(200 + i), 1'b0, 1'b0);
        checkOutput("t4_in_ready", 64'(in_ready), 64'd0);
        checkOutput("t4_head_rd", 64'(wr_addr), 64'd10);
        idle(3);
        checkOutput("t4_in_ready_back", 64'(in_ready), 64'd1);

        // Flush with two buffered ops and a third offered
        applyStimulus(1'b1, rInstr(1, 2, 20, 0, 'h25), 32'd1, 32'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, rInstr(1, 2, 21, 0, 'h26), 32'd3, 32'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, rInstr(1, 2, 22, 0, 'h27), 32'd5, 32'd6, 1'b1, 1'b1);
        checkOutput("t5_out_valid", 64'(out_valid), 64'd0);
        checkOutput("t5_in_ready", 64'(in_ready), 64'd1);
        idle(3);

        // Illegal opcode, then LUI to $0
        applyStimulus(1'b1, {6'h3F, 26'h1234567}, 32'hAAAA, 32'hBBBB, 1'b1, 1'b0);
        checkOutput("t6_illegal", 64'(illegal), 64'd1);
        checkOutput("t6_ill_ctrl", 64'(alu_ctrl), 64'd0);
        checkOutput("t6_ill_wr_en", 64'(wr_en), 64'd0);
        applyStimulus(1'b1, iInstr('h0F, 0, 0, 'h1234), 32'hAAAA, 32'hBBBB, 1'b1, 1'b0);
        checkOutput("t6_lui_ctrl", 64'(alu_ctrl), 64'h2000);
        checkOutput("t6_lui_db", 64'(alu_db), 64'h1234);
        checkOutput("t6_lui_wr_en", 64'(wr_en), 64'd0);
        // NOP
        applyStimulus(1'b1, 32'h0, 32'h55, 32'h66, 1'b1, 1'b0);
        checkOutput("nop_ctrl", 64'(alu_ctrl), 64'h0400);
        checkOutput("nop_wr_en", 64'(wr_en), 64'd0);
        idle(2);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++)
            applyStimulus($urandom_range(0, 9) < 7, randInstr(), $urandom, $urandom,
                          $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
